perceptron_trainer: RTL and testbench

Sequential trainer for the two-input perceptron used in the MLP datapath. It runs the perceptron learning rule over a training set streamed in by an upstream sample source. The set is replayed once per epoch, and the trainer stops on the first error-free epoch or after a bounded number of epochs. The resulting weights and bias are driven out at the same signed width the inference perceptrons consume, ready to be loaded into an MLP neuron.

---
 rtl/perceptron_trainer.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_perceptron_trainer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/perceptron_trainer.sv
// -----------------------------------------------------------------------------
// perceptron_trainer
//
// Sequential trainer for a two-input perceptron. A training set is streamed in
// by an upstream source (valid/ready handshake) and replayed once per epoch.
// Each sample goes through three phases: capture (WAIT_SAMPLE), classify with
// the current weights (PREDICT), and apply the perceptron learning rule
// (UPDATE). The last sample of an epoch, flagged by i_sample_last, adds one
// EPOCH_END cycle where the trainer decides to stop (error-free epoch or epoch
// limit reached) or to replay the set. Weights and bias are kept at the same
// signed width W used by the inference perceptrons and saturate on update.
//
// Parameters
//   W           signed width of inputs, weights and bias
//   MAX_EPOCHS  epoch limit (1..255)
//   LR_SHIFT    learning rate 2^-LR_SHIFT, applied as x >>> LR_SHIFT
//
// Ports
//   i_clk            clock, all state changes on the rising edge
//   i_rst            synchronous active-high reset, priority over everything
//   i_start          begin training (honoured only in IDLE or DONE)
//   i_sample_valid   upstream sample present
//   o_sample_ready   trainer accepts a sample (high only in WAIT_SAMPLE)
//   i_x1, i_x2       signed sample features
//   i_target         desired class (0/1)
//   i_sample_last    marks the final sample of the epoch
//   o_w1, o_w2       current weights
//   o_bias           current bias
//   o_busy           high in every state except IDLE/DONE
//   o_done           level, high in DONE until the next start or reset
//   o_converged      valid with o_done: 1 = an error-free epoch was reached
//   o_epoch_count    completed epochs
//   o_err_count      misclassifications in the current epoch (saturates at 255)
// -----------------------------------------------------------------------------
module perceptron_trainer #(
  parameter int W          = 10,
  parameter int MAX_EPOCHS = 16,
  parameter int LR_SHIFT   = 0
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic                i_sample_valid,
  output logic                o_sample_ready,
  input  logic signed [W-1:0] i_x1,
  input  logic signed [W-1:0] i_x2,
  input  logic                i_target,
  input  logic                i_sample_last,
  output logic signed [W-1:0] o_w1,
  output logic signed [W-1:0] o_w2,
  output logic signed [W-1:0] o_bias,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_converged,
  output logic [7:0]          o_epoch_count,
  output logic [7:0]          o_err_count
);

  // Width of the dot product: two W x W products plus a bias cannot exceed
  // 2W+2 signed bits, so the sum never overflows.
  localparam int SW = 2 * W + 2;

  localparam logic signed [SW-1:0] SUM_ZERO    = {SW{1'b0}};
  localparam logic [7:0]           EPOCH_LIMIT = 8'(MAX_EPOCHS);
  localparam logic [7:0]           ERR_SAT     = 8'd255;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_WAIT_SAMPLE = 3'd1,
    S_PREDICT     = 3'd2,
    S_UPDATE      = 3'd3,
    S_EPOCH_END   = 3'd4,
    S_DONE        = 3'd5
  } state_t;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------

  // Clamp a (W+2)-bit intermediate into the signed W-bit range.
  function automatic logic signed [W-1:0] sat_w(input logic signed [W+1:0] v);
    logic signed [W+1:0] v_max;
    logic signed [W+1:0] v_min;
    v_max = {3'b000, {(W-1){1'b1}}};
    v_min = {3'b111, {(W-1){1'b0}}};
    if (v > v_max) begin
      sat_w = v_max[W-1:0];
    end else if (v < v_min) begin
      sat_w = v_min[W-1:0];
    end else begin
      sat_w = v[W-1:0];
    end
  endfunction

  // w + e*d for e in {-1, 0, +1}, evaluated two bits wider so that the
  // subsequent clamp sees the true result rather than a wrapped one.
  function automatic logic signed [W+1:0] add_err(
    input logic signed [W-1:0] w,
    input logic signed [W-1:0] d,
    input logic signed [1:0]   e
  );
    logic signed [W+1:0] w_x;
    logic signed [W+1:0] d_x;
    w_x = (W+2)'(w);
    d_x = (W+2)'(d);
    case (e)
      2'sb01:  add_err = w_x + d_x;
      2'sb11:  add_err = w_x - d_x;
      default: add_err = w_x;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t                r_state;
  logic signed [W-1:0]   r_x1;
  logic signed [W-1:0]   r_x2;
  logic                  r_target;
  logic                  r_last;
  logic signed [1:0]     r_err;
  logic signed [W-1:0]   r_w1;
  logic signed [W-1:0]   r_w2;
  logic signed [W-1:0]   r_bias;
  logic [7:0]            r_epoch_count;
  logic [7:0]            r_err_count;
  logic                  r_converged;
  logic                  r_done;
  logic                  r_busy;
  logic                  r_sample_ready;

  // ---------------------------------------------------------------------------
  // Combinational datapath
  // ---------------------------------------------------------------------------
  logic signed [SW-1:0]  w_sum;
  logic                  w_y;
  logic signed [1:0]     w_err;
  logic signed [W-1:0]   w_x1_step;
  logic signed [W-1:0]   w_x2_step;
  logic signed [W-1:0]   w_one;
  logic signed [W-1:0]   w_w1_next;
  logic signed [W-1:0]   w_w2_next;
  logic signed [W-1:0]   w_bias_next;
  logic [7:0]            w_err_count_inc;

  // Operands are sign-extended to the full sum width before multiplying.
  assign w_sum = SW'(r_w1) * SW'(r_x1) + SW'(r_w2) * SW'(r_x2) + SW'(r_bias);
  assign w_y   = (w_sum >= SUM_ZERO);

  // Classification error for the captured sample: target minus predicted class
  always_comb begin
    w_err = 2'sb00;
    if (r_target && !w_y) begin
      w_err = 2'sb01;
    end else if (!r_target && w_y) begin
      w_err = 2'sb11;
    end else begin
      w_err = 2'sb00;
    end
  end

  // Learning rate is applied to the features only; the bias moves by +/-1.
  assign w_x1_step = r_x1 >>> LR_SHIFT;
  assign w_x2_step = r_x2 >>> LR_SHIFT;
  assign w_one     = {{(W-1){1'b0}}, 1'b1};

  assign w_w1_next   = sat_w(add_err(r_w1, w_x1_step, r_err));
  assign w_w2_next   = sat_w(add_err(r_w2, w_x2_step, r_err));
  assign w_bias_next = sat_w(add_err(r_bias, w_one, r_err));

  assign w_err_count_inc = (r_err_count == ERR_SAT) ? ERR_SAT : (r_err_count + 8'd1);

  // ---------------------------------------------------------------------------
  // Training FSM: state, sample capture, weight updates and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= S_IDLE;
      r_x1           <= {W{1'b0}};
      r_x2           <= {W{1'b0}};
      r_target       <= 1'b0;
      r_last         <= 1'b0;
      r_err          <= 2'sb00;
      r_w1           <= {W{1'b0}};
      r_w2           <= {W{1'b0}};
      r_bias         <= {W{1'b0}};
      r_epoch_count  <= 8'd0;
      r_err_count    <= 8'd0;
      r_converged    <= 1'b0;
      r_done         <= 1'b0;
      r_busy         <= 1'b0;
      r_sample_ready <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_w1           <= {W{1'b0}};
            r_w2           <= {W{1'b0}};
            r_bias         <= {W{1'b0}};
            r_epoch_count  <= 8'd0;
            r_err_count    <= 8'd0;
            r_converged    <= 1'b0;
            r_done         <= 1'b0;
            r_busy         <= 1'b1;
            r_sample_ready <= 1'b1;
            r_state        <= S_WAIT_SAMPLE;
          end
        end

        // i_start is deliberately not looked at in any busy state.
        S_WAIT_SAMPLE: begin
          if (i_sample_valid && r_sample_ready) begin
            r_x1           <= i_x1;
            r_x2           <= i_x2;
            r_target       <= i_target;
            r_last         <= i_sample_last;
            r_sample_ready <= 1'b0;
            r_state        <= S_PREDICT;
          end
        end

        S_PREDICT: begin
          r_err   <= w_err;
          r_state <= S_UPDATE;
        end

        // Weights only ever change on the edge that leaves this state.
        S_UPDATE: begin
          if (r_err != 2'sb00) begin
            r_w1        <= w_w1_next;
            r_w2        <= w_w2_next;
            r_bias      <= w_bias_next;
            r_err_count <= w_err_count_inc;
          end
          if (r_last) begin
            r_state <= S_EPOCH_END;
          end else begin
            r_sample_ready <= 1'b1;
            r_state        <= S_WAIT_SAMPLE;
          end
        end

        // r_err_count already includes the final sample of the epoch here.
        S_EPOCH_END: begin
          r_epoch_count <= r_epoch_count + 8'd1;
          if (r_err_count == 8'd0) begin
            r_converged <= 1'b1;
            r_done      <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_DONE;
          end else if ((r_epoch_count + 8'd1) == EPOCH_LIMIT) begin
            r_converged <= 1'b0;
            r_done      <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_DONE;
          end else begin
            r_err_count    <= 8'd0;
            r_sample_ready <= 1'b1;
            r_state        <= S_WAIT_SAMPLE;
          end
        end

        default: begin
          r_busy         <= 1'b0;
          r_done         <= 1'b0;
          r_sample_ready <= 1'b0;
          r_state        <= S_IDLE;
        end
      endcase
    end
  end

  assign o_sample_ready = r_sample_ready;
  assign o_w1           = r_w1;
  assign o_w2           = r_w2;
  assign o_bias         = r_bias;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_converged    = r_converged;
  assign o_epoch_count  = r_epoch_count;
  assign o_err_count    = r_err_count;

endmodule

// File: tb/tb_perceptron_trainer.sv
`timescale 1ns/1ps
module tb_perceptron_trainer;

  localparam int W      = 10;
  localparam int MAX_EP = 16;
  localparam int LRS    = 0;
  localparam int WMAX   = 511;
  localparam int WMIN   = -512;

  logic                i_clk = 1'b0;
  logic                i_rst = 1'b1;
  logic                i_start = 1'b0;
  logic                i_sample_valid = 1'b0;
  logic                o_sample_ready;
  logic signed [W-1:0] i_x1 = '0;
  logic signed [W-1:0] i_x2 = '0;
  logic                i_target = 1'b0;
  logic                i_sample_last = 1'b0;
  logic signed [W-1:0] o_w1;
  logic signed [W-1:0] o_w2;
  logic signed [W-1:0] o_bias;
  logic                o_busy;
  logic                o_done;
  logic                o_converged;
  logic [7:0]          o_epoch_count;
  logic [7:0]          o_err_count;

  perceptron_trainer #(.W(W), .MAX_EPOCHS(MAX_EP), .LR_SHIFT(LRS)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_start        (i_start),
    .i_sample_valid (i_sample_valid),
    .o_sample_ready (o_sample_ready),
    .i_x1           (i_x1),
    .i_x2           (i_x2),
    .i_target       (i_target),
    .i_sample_last  (i_sample_last),
    .o_w1           (o_w1),
    .o_w2           (o_w2),
    .o_bias         (o_bias),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_converged    (o_converged),
    .o_epoch_count  (o_epoch_count),
    .o_err_count    (o_err_count)
  );

  always #5 i_clk = ~i_clk;

  // Behavioural model: perceptron state plus expected status outputs
  int m_w1, m_w2, m_b, m_errc, m_epoch;
  bit m_done;
  bit e_busy, e_ready, e_done, e_conv;
  bit chk_en = 1'b0;

  int checks = 0;
  int failures = 0;
  int hs_count = 0;
  int exp_hs = 0;

  int sx1[4];
  int sx2[4];
  int st[4];

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, req);
    end
  endtask

  function automatic int sat(input int v);
    if (v > WMAX) return WMAX;
    if (v < WMIN) return WMIN;
    return v;
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic model_reset();
    m_w1 = 0; m_w2 = 0; m_b = 0; m_errc = 0; m_epoch = 0; m_done = 1'b0;
    e_busy = 1'b0; e_ready = 1'b0; e_done = 1'b0; e_conv = 1'b0;
  endtask

  // Count accepted samples as the DUT sees them
  always @(posedge i_clk) begin
    if (i_sample_valid && o_sample_ready) hs_count <= hs_count + 1;
  end

  // Compare every output against the model on every falling edge
  always @(negedge i_clk) begin
    if (chk_en) begin
      check("w1",          32'($signed(o_w1)),   m_w1);
      check("w2",          32'($signed(o_w2)),   m_w2);
      check("bias",        32'($signed(o_bias)), m_b);
      check("err_count",   32'(o_err_count),     m_errc);
      check("epoch_count", 32'(o_epoch_count),   m_epoch);
      check("busy",        32'(o_busy),          32'(e_busy));
      check("done",        32'(o_done),          32'(e_done));
      check("converged",   32'(o_converged),     32'(e_conv));
      check("sample_ready",32'(o_sample_ready),  32'(e_ready));
    end
  end

  task automatic do_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    m_w1 = 0; m_w2 = 0; m_b = 0; m_errc = 0; m_epoch = 0; m_done = 1'b0;
    e_busy = 1'b1; e_ready = 1'b1; e_done = 1'b0; e_conv = 1'b0;
  endtask

  // Drive one training run of n samples. first_gap/gap = cycles with valid
  // low before a sample; rst_epoch/start_epoch (1-based, 0 = never) inject a
  // reset in PREDICT or a start pulse in WAIT_SAMPLE of sample 0 of that epoch.
  task automatic run_set(input int n, input int first_gap, input int gap,
                         input int rst_epoch, input int start_epoch);
    longint sum;
    int     y, err;
    do_start();
    for (int ep = 0; ep < MAX_EP + 2 && !m_done; ep++) begin
      for (int k = 0; k < n; k++) begin
        i_x1 = W'(sx1[k]);
        i_x2 = W'(sx2[k]);
        i_target = st[k][0];
        i_sample_last = (k == n - 1);
        for (int g = 0; g < ((ep == 0 && k == 0) ? first_gap : gap); g++) begin
          i_sample_valid = 1'b0;
          tick();
        end
        i_sample_valid = 1'b1;
        i_start = (ep + 1 == start_epoch) && (k == 0);
        tick();                       // handshake edge
        i_start = 1'b0;
        exp_hs++;
        e_ready = 1'b0;
        if (ep + 1 == rst_epoch && k == 0) begin
          i_sample_valid = 1'b0;
          i_rst = 1'b1;
          tick();
          i_rst = 1'b0;
          model_reset();
          return;
        end
        tick();                       // leaving PREDICT
        sum = longint'(m_w1) * sx1[k] + longint'(m_w2) * sx2[k] + m_b;
        y = (sum >= 0) ? 1 : 0;
        err = st[k] - y;
        tick();                       // leaving UPDATE
        if (err != 0) begin
          m_w1 = sat(m_w1 + err * (sx1[k] >>> LRS));
          m_w2 = sat(m_w2 + err * (sx2[k] >>> LRS));
          m_b  = sat(m_b + err);
          m_errc = (m_errc == 255) ? 255 : m_errc + 1;
        end
        if (k != n - 1) begin
          e_ready = 1'b1;
        end else begin
          tick();                     // leaving EPOCH_END
          m_epoch++;
          if (m_errc == 0) begin
            m_done = 1'b1; e_conv = 1'b1; e_done = 1'b1; e_busy = 1'b0;
          end else if (m_epoch == MAX_EP) begin
            m_done = 1'b1; e_done = 1'b1; e_busy = 1'b0;
          end else begin
            m_errc = 0; e_ready = 1'b1;
          end
        end
      end
    end
    i_sample_valid = 1'b0;
    tick();
    tick();
    check("handshakes", hs_count, exp_hs);
  endtask

  task automatic load(input int n, input int a0, input int b0, input int t0,
                      input int a1, input int b1, input int t1,
                      input int a2, input int b2, input int t2,
                      input int a3, input int b3, input int t3);
    sx1[0] = a0; sx2[0] = b0; st[0] = t0;
    sx1[1] = a1; sx2[1] = b1; st[1] = t1;
    sx1[2] = a2; sx2[2] = b2; st[2] = t2;
    sx1[3] = a3; sx2[3] = b3; st[3] = t3;
    if (n < 1) $display("empty set");
  endtask

  initial begin
    model_reset();
    i_rst = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    i_rst = 1'b0;
    tick();
    check("rst_w1",    32'($signed(o_w1)), 0);
    check("rst_busy",  32'(o_busy), 0);
    check("rst_ready", 32'(o_sample_ready), 0);

    // AND set: 10 idle cycles after start, reset during PREDICT of epoch 2
    load(4, 0, 0, 0,  0, 1, 0,  1, 0, 0,  1, 1, 1);
    run_set(4, 10, 0, 2, 0);
    tick();
    check("abort_epoch", 32'(o_epoch_count), 0);
    check("abort_done",  32'(o_done), 0);

    // AND set again, valid held high, stray start during epoch 3
    run_set(4, 0, 0, 0, 3);
    check("and_done",  32'(o_done), 1);
    check("and_conv",  32'(o_converged), 1);
    check("and_epoch", 32'(o_epoch_count), 6);
    check("and_w1",    32'($signed(o_w1)), 2);
    check("and_w2",    32'($signed(o_w2)), 1);
    check("and_bias",  32'($signed(o_bias)), -3);

    // XOR set: never separable, runs to the epoch limit
    load(4, 0, 0, 0,  0, 1, 1,  1, 0, 1,  1, 1, 0);
    run_set(4, 0, 2, 0, 0);
    check("xor_done",  32'(o_done), 1);
    check("xor_conv",  32'(o_converged), 0);
    check("xor_epoch", 32'(o_epoch_count), 16);
    check("xor_errnz", 32'(o_err_count != 8'd0), 1);

    // Single extreme sample: w2 clamps at the top of the range
    load(1, 511, -512, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0);
    run_set(1, 0, 0, 0, 0);
    check("sat1_w1",    32'($signed(o_w1)), -511);
    check("sat1_w2",    32'($signed(o_w2)), 511);
    check("sat1_bias",  32'($signed(o_bias)), -1);
    check("sat1_epoch", 32'(o_epoch_count), 2);
    check("sat1_conv",  32'(o_converged), 1);

    // Second sample drives w1 below the range: -511-100 clamps at -512
    load(2, 511, -512, 0,  100, 511, 0,  0, 0, 0,  0, 0, 0);
    run_set(2, 0, 0, 0, 0);
    check("sat2_w1",    32'($signed(o_w1)), -512);
    check("sat2_w2",    32'($signed(o_w2)), 0);
    check("sat2_bias",  32'($signed(o_bias)), -2);
    check("sat2_epoch", 32'(o_epoch_count), 2);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
